// File: rtl/cnn_scan_controller.sv
// Raster scan sequencer for the 3x3 edge-detect accelerator over one frame.
// Issues interior pixels, gathers delayed results and keeps per-frame stats.
module cnn_scan_controller #(
    parameter int IMG_DIM    = 64,
    parameter int IDX_W      = 7,
    parameter int CNT_W      = 12,
    parameter int DET_THRESH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             pause,
    input  logic             abort,
    output logic             acc_start,
    output logic [IDX_W-1:0] acc_row,
    output logic [IDX_W-1:0] acc_col,
    input  logic             acc_valid,
    input  logic             acc_detect,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] det_count,
    output logic [IDX_W-1:0] first_row,
    output logic [IDX_W-1:0] first_col,
    output logic             first_found,
    output logic             frame_detect,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(IMG_DIM - 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH    = CNT_W'(DET_THRESH);

    state_t state_q, state_d;

    logic [IDX_W-1:0] prev_row, prev_col;
    logic [CNT_W-1:0] issue_cnt, res_cnt;
    logic             pend_q;
    logic             start_frame;
    logic             last_px;
    logic             hit;
    logic             stray;

    assign start_frame = (state_q == IDLE) && frame_start && !abort;
    assign last_px     = (acc_row == LAST_IDX) && (acc_col == LAST_IDX);
    assign hit         = acc_valid && acc_detect;
    // A result is only legitimate in IDLE/DONE if a pixel went out last cycle
    assign stray       = acc_valid && !pend_q &&
                         ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d   = state_q;
        acc_start = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_frame) state_d = SCAN;
            end
            SCAN: begin
                busy      = 1'b1;
                acc_start = !pause && !abort;
                if (abort) state_d = IDLE;
                else if (!pause && last_px) state_d = DRAIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = abort ? IDLE : DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_row  <= '0;
            acc_col  <= '0;
            prev_row <= '0;
            prev_col <= '0;
            pend_q   <= 1'b0;
        end else begin
            pend_q <= acc_start || (busy && abort);
            if (start_frame) begin
                acc_row <= FIRST_IDX;
                acc_col <= FIRST_IDX;
            end else if (acc_start) begin
                prev_row <= acc_row;
                prev_col <= acc_col;
                if (!last_px) begin
                    if (acc_col == LAST_IDX) begin
                        acc_col <= FIRST_IDX;
                        acc_row <= acc_row + FIRST_IDX;
                    end else begin
                        acc_col <= acc_col + FIRST_IDX;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            res_cnt   <= '0;
        end else if (start_frame) begin
            issue_cnt <= '0;
            res_cnt   <= '0;
        end else begin
            if (acc_start) issue_cnt <= issue_cnt + CNT_W'(1);
            if (acc_valid) res_cnt <= res_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_count   <= '0;
            first_row   <= '0;
            first_col   <= '0;
            first_found <= 1'b0;
        end else if (start_frame) begin
            det_count   <= '0;
            first_row   <= '0;
            first_col   <= '0;
            first_found <= 1'b0;
        end else if (hit) begin
            if (det_count != CNT_MAX) det_count <= det_count + CNT_W'(1);
            if (!first_found) begin
                first_row   <= prev_row;
                first_col   <= prev_col;
                first_found <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_detect <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (state_q == DONE) frame_detect <= (det_count >= THRESH);
            if (start_frame) begin
                err <= 1'b0;
            end else if (stray ||
                         ((state_q == DONE) && (res_cnt != issue_cnt))) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cnn_scan_controller.sv
// Bench for cnn_scan_controller: behavioural accelerator plus raster reference
// model; directed and randomized frames with pauses, abort and async reset.
module tb_cnn_scan_controller;

    localparam int N    = 64;
    localparam int SIDE = N - 2;
    localparam int NPIX = SIDE * SIDE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        pause = 1'b0;
    logic        abort = 1'b0;
    logic        acc_start;
    logic [6:0]  acc_row, acc_col;
    logic        acc_valid, acc_detect;
    logic        busy, done;
    logic [11:0] det_count;
    logic [6:0]  first_row, first_col;
    logic        first_found, frame_detect, err;

    logic        acc_valid_m = 1'b0;
    logic        acc_detect_m = 1'b0;
    logic        inj = 1'b0;

    logic [7:0]  img [0:N-1][0:N-1];

    int n_assert = 0;
    int n_fail = 0;

    assign acc_valid  = acc_valid_m | inj;
    assign acc_detect = acc_detect_m;

    cnn_scan_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .pause        (pause),
        .abort        (abort),
        .acc_start    (acc_start),
        .acc_row      (acc_row),
        .acc_col      (acc_col),
        .acc_valid    (acc_valid),
        .acc_detect   (acc_detect),
        .busy         (busy),
        .done         (done),
        .det_count    (det_count),
        .first_row    (first_row),
        .first_col    (first_col),
        .first_found  (first_found),
        .frame_detect (frame_detect),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Laplacian-style kernel: 8*centre minus the eight neighbours
    function automatic bit detect_at(input int r, input int c);
        int s;
        s = 8 * int'(img[r][c]);
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0) s -= int'(img[r+dr][c+dc]);
        return s >= 600;
    endfunction

    always @(posedge clk) begin
        acc_valid_m <= acc_start;
        if (acc_start) acc_detect_m <= detect_at(int'(acc_row), int'(acc_col));
        else           acc_detect_m <= 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_img();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) img[r][c] = 8'd0;
    endtask

    task automatic random_img();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                img[r][c] = ($urandom_range(0, 99) < 3) ?
                            8'($urandom_range(128, 255)) : 8'd0;
    endtask

    task automatic ref_model(output int cnt, output int ff,
                             output int fr, output int fc);
        cnt = 0; ff = 0; fr = 0; fc = 0;
        for (int r = 1; r <= SIDE; r++)
            for (int c = 1; c <= SIDE; c++)
                if (detect_at(r, c)) begin
                    cnt++;
                    if (ff == 0) begin ff = 1; fr = r; fc = c; end
                end
    endtask

    task automatic run_frame(input int p1_at, input int p1_len,
                             input int p2_at, input int p2_len,
                             input int abort_at,
                             output int done_cyc, output int n_iss,
                             output int seq_err, output int pause_err);
        int cyc, p1_left, p2_left;
        bit aborted;
        cyc = 0; aborted = 0; done_cyc = 0; n_iss = 0;
        seq_err = 0; pause_err = 0;
        p1_left = p1_len; p2_left = p2_len;
        @(posedge clk); #1;
        frame_start = 1'b1;
        while (cyc < 5000 && done_cyc == 0 && !aborted) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
            pause = 1'b0;
            abort = 1'b0;
            cyc++;
            if (n_iss == p1_at && p1_left > 0) begin
                pause = 1'b1; p1_left--;
            end else if (n_iss == p2_at && p2_left > 0) begin
                pause = 1'b1; p2_left--;
            end
            if (n_iss == abort_at) begin
                abort = 1'b1; aborted = 1;
            end
            @(negedge clk);
            if (acc_start) begin
                if (pause) pause_err++;
                if (int'(acc_row) != 1 + n_iss / SIDE ||
                    int'(acc_col) != 1 + n_iss % SIDE) seq_err++;
                n_iss++;
            end
            if (done) done_cyc = cyc;
        end
        if (abort_at < 0) check("done_within_budget", 32'(done_cyc != 0), 1);
        @(posedge clk); #1;
        pause = 1'b0;
        abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic full_frame_checks(input string tag, input int p1_at,
                                     input int p1_len, input int p2_at,
                                     input int p2_len);
        int dc, ni, se, pe, ecnt, eff, efr, efc;
        ref_model(ecnt, eff, efr, efc);
        run_frame(p1_at, p1_len, p2_at, p2_len, -1, dc, ni, se, pe);
        check({tag, "_issues"}, 32'(ni), 32'(NPIX));
        check({tag, "_seq"}, 32'(se), 0);
        check({tag, "_pause_issue"}, 32'(pe), 0);
        check({tag, "_done_cycle"}, 32'(dc), 32'(NPIX + 2 + p1_len + p2_len));
        check({tag, "_det_count"}, 32'(det_count), 32'(ecnt));
        check({tag, "_first_found"}, 32'(first_found), 32'(eff));
        if (eff != 0) begin
            check({tag, "_first_row"}, 32'(first_row), 32'(efr));
            check({tag, "_first_col"}, 32'(first_col), 32'(efc));
        end
        check({tag, "_frame_detect"}, 32'(frame_detect), 32'(ecnt >= 16));
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_busy_after"}, 32'(busy), 0);
        check({tag, "_done_single"}, 32'(done), 0);
    endtask

    initial begin
        int dc, ni, se, pe, ndone;

        clear_img();
        #12;
        check("rst_acc_start", 32'(acc_start), 0);
        check("rst_row_col", 32'({acc_row, acc_col}), 0);
        check("rst_busy_done", 32'({busy, done}), 0);
        check("rst_stats", 32'({det_count, first_found, frame_detect, err}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        full_frame_checks("zero", -1, 0, -1, 0);

        img[10][20] = 8'd255;
        full_frame_checks("single", -1, 0, -1, 0);

        clear_img();
        for (int c = 0; c < N; c++) img[5][c] = 8'd255;
        full_frame_checks("row5", -1, 0, -1, 0);
        full_frame_checks("row5_pause", 100, 10, 10 * SIDE, 10);

        run_frame(-1, 0, -1, 0, 500, dc, ni, se, pe);
        check("abort_issues", 32'(ni), 500);
        check("abort_seq", 32'(se), 0);
        check("abort_no_done", 32'(dc), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_hold_fd", 32'(frame_detect), 1);
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("abort_quiet", 32'(ndone), 0);

        for (int k = 0; k < 2; k++) begin
            random_img();
            full_frame_checks($sformatf("rand%0d", k),
                              int'($urandom_range(1, 1800)),
                              int'($urandom_range(1, 15)),
                              int'($urandom_range(1900, 3800)),
                              int'($urandom_range(1, 15)));
        end

        clear_img();
        for (int c = 0; c < N; c++) img[5][c] = 8'd255;
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (300) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs",
              32'({acc_start, busy, done, first_found, frame_detect, err}), 0);
        check("mid_rst_counts", 32'({det_count, acc_row, acc_col}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_err", 32'(err), 0);
        check("post_rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        inj = 1'b1;
        @(posedge clk); #1;
        inj = 1'b0;
        @(negedge clk);
        check("stray_valid_err", 32'(err), 1);
        full_frame_checks("after_err", -1, 0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
